// File: rtl/spi_eep_if.sv
// SPI bus and status bundle between the DSO SPI master and the calibration EEPROM responder.
// MISO is kept as a separate port on the responder because it is tri-stated.
interface spi_eep_if;
   logic       SS_n;
   logic       SCLK;
   logic       MOSI;
   logic       frm_done;
   logic       wr_done;
   logic [7:0] rd_data;

   modport master (output SS_n, SCLK, MOSI, input frm_done, wr_done, rd_data);
   modport slave  (input SS_n, SCLK, MOSI, output frm_done, wr_done, rd_data);
endinterface

// File: rtl/spi_eep_slave.sv
// SPI responder for the 64x8 calibration EEPROM: oversampled 16-bit frames, read/write decode.
// Define CAL_WPROT_EN to write-protect addresses 0x00-0x0F behind an op 2'b11 / 8'hA5 unlock frame.
module spi_eep_slave #(
   parameter int         ADDR_W   = 6,
   parameter logic [7:0] INIT_VAL = 8'h00
) (
   input  logic         clk,
   input  logic         rst_n,
   spi_eep_if.slave     bus,
   output logic         MISO
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam int         DEPTH = 1 << ADDR_W;

   logic              ss_p0, ss_p1;
   logic              sclk_p0, sclk_p1, sclk_p2;
   logic              mosi_p0, mosi_p1;
   logic              rise, fall;
   logic [1:0]        state;
   logic [4:0]        bit_cnt;
   logic [15:0]       tx_shift;
   logic [15:0]       rx_shift;
   logic              frame_rdy;
   logic [7:0]        rd_data;
   logic              frm_done;
   logic              wr_done;
   logic [7:0]        mem [DEPTH];
   logic [1:0]        op;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        data;
   logic              wr_ok;

   // Two-flop synchronizers; SCLK gets a third flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_p0   <= 1'b1;
         ss_p1   <= 1'b1;
         sclk_p0 <= 1'b1;
         sclk_p1 <= 1'b1;
         sclk_p2 <= 1'b1;
         mosi_p0 <= 1'b0;
         mosi_p1 <= 1'b0;
      end else begin
         ss_p0   <= bus.SS_n;
         ss_p1   <= ss_p0;
         sclk_p0 <= bus.SCLK;
         sclk_p1 <= sclk_p0;
         sclk_p2 <= sclk_p1;
         mosi_p0 <= bus.MOSI;
         mosi_p1 <= mosi_p0;
      end
   end

   assign rise = sclk_p1 & ~sclk_p2;
   assign fall = ~sclk_p1 & sclk_p2;

   assign op   = rx_shift[15:14];
   assign addr = rx_shift[8 +: ADDR_W];
   assign data = rx_shift[7:0];

`ifdef CAL_WPROT_EN
   logic unlock;
   assign wr_ok = (addr >= ADDR_W'(16)) || unlock;
`else
   assign wr_ok = 1'b1;
`endif

   // Frame FSM: capture on SCLK rise, advance MISO on SCLK fall, decode once per complete frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         frame_rdy <= 1'b0;
         rd_data   <= '0;
         frm_done  <= 1'b0;
         wr_done   <= 1'b0;
`ifdef CAL_WPROT_EN
         unlock    <= 1'b0;
`endif
         for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
      end else begin
         frm_done <= 1'b0;
         wr_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (!ss_p1) begin
                  state    <= SHIFT;
                  bit_cnt  <= '0;
                  tx_shift <= {8'h00, rd_data};
               end
            end
            SHIFT: begin
               if (ss_p1) begin
                  state <= IDLE;
               end else if (rise) begin
                  rx_shift <= {rx_shift[14:0], mosi_p1};
                  bit_cnt  <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd15) begin
                     state     <= DONE;
                     frame_rdy <= 1'b1;
                  end
               end else if (fall && bit_cnt != 5'd0) begin
                  tx_shift <= {tx_shift[14:0], 1'b0};
               end
            end
            DONE: begin
               // Decode happens once; the FSM then parks here ignoring SCLK until SS_n rises
               if (frame_rdy) begin
                  frame_rdy <= 1'b0;
                  frm_done  <= 1'b1;
                  if (op == 2'b01 && wr_ok) begin
                     mem[addr] <= data;
                     wr_done   <= 1'b1;
                  end else if (op == 2'b00) begin
                     rd_data <= mem[addr];
                  end
`ifdef CAL_WPROT_EN
                  unlock <= (op == 2'b11) && (data == 8'hA5);
`endif
               end
               if (ss_p1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign MISO         = ss_p1 ? 1'bz : tx_shift[15];
   assign bus.rd_data  = rd_data;
   assign bus.frm_done = frm_done;
   assign bus.wr_done  = wr_done;

endmodule

// File: tb/tb_spi_eep_slave.sv
// Directed bench for spi_eep_slave: drives 16-bit SPI frames at clk/16 and checks responses.
// MISO is pulled up so a released line reads as 1.
module tb_spi_eep_slave;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_eep_if bus ();
   wire miso;
   pullup (miso);

   spi_eep_slave dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .MISO  (miso)
   );

   int total = 0;
   int bad = 0;
   int n_frm = 0;
   int n_wr = 0;
   int exp_frm = 0;
   int exp_wr = 0;
   int unstable = 0;
   logic [15:0] r;

   always @(negedge clk) begin
      if (bus.frm_done) n_frm <= n_frm + 1;
      if (bus.wr_done)  n_wr  <= n_wr + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Mode-3 style master: data changes on SCLK fall, both sides sample on rise
   task automatic frame(input logic [15:0] w, input int nclk, output logic [15:0] rx);
      logic a;
      rx = '0;
      bus.SS_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < nclk; i++) begin
         bus.SCLK = 1'b0;
         bus.MOSI = (i < 16) ? w[15-i] : 1'b1;
         repeat (4) @(negedge clk);
         a = miso;
         repeat (4) @(negedge clk);
         if (miso !== a) unstable++;
         bus.SCLK = 1'b1;
         rx = {rx[14:0], miso};
         repeat (8) @(negedge clk);
      end
      bus.SS_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      bus.SS_n = 1'b1;
      bus.SCLK = 1'b1;
      bus.MOSI = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_frm_done", bus.frm_done, 0);
      check("rst_wr_done", bus.wr_done, 0);
      check("rst_rd_data", bus.rd_data, 8'h00);
      check("rst_miso_z", miso, 1'b1);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      frame(16'h0000, 16, r);
      frame(16'h0000, 16, r);
      exp_frm += 2;
      check("rd0_miso", r, 16'h0000);
      check("rd0_data", bus.rd_data, 8'h00);
      check("rd0_frm_cnt", n_frm, exp_frm);

`ifdef CAL_WPROT_EN
      frame(16'hC0A5, 16, r);
      exp_frm++;
`endif
      frame(16'h4A3C, 16, r);
      exp_frm++;
      exp_wr++;
      check("wr0a_wr_cnt", n_wr, exp_wr);
      check("wr0a_rd_data_kept", bus.rd_data, 8'h00);
      frame(16'h0A00, 16, r);
      check("rd0a_data", bus.rd_data, 8'h3C);
      frame(16'h0000, 16, r);
      exp_frm += 2;
      check("rd0a_miso", r, 16'h003C);
      check("rd00_data", bus.rd_data, 8'h00);
      check("idle_miso_z", miso, 1'b1);
      check("frm_cnt2", n_frm, exp_frm);

      frame(16'h4555, 9, r);
      check("abort_frm_cnt", n_frm, exp_frm);
      check("abort_wr_cnt", n_wr, exp_wr);
      check("abort_rd_data", bus.rd_data, 8'h00);
      frame(16'h0500, 16, r);
      exp_frm++;
      check("abort_addr5", bus.rd_data, 8'h00);

      frame(16'h7F81, 20, r);
      exp_frm++;
      exp_wr++;
      check("extra_wr_cnt", n_wr, exp_wr);
      check("extra_frm_cnt", n_frm, exp_frm);
      frame(16'h3F00, 16, r);
      check("rd3f_data", bus.rd_data, 8'h81);
      frame(16'h0000, 16, r);
      exp_frm += 2;
      check("rd3f_miso", r, 16'h0081);

      frame(16'h8A77, 16, r);
      check("op10_wr_cnt", n_wr, exp_wr);
      check("op10_rd_data", bus.rd_data, 8'h00);
      frame(16'h0A00, 16, r);
      exp_frm += 2;
      check("op10_store", bus.rd_data, 8'h3C);

      frame(16'h4211, 16, r);
      exp_frm++;
`ifndef CAL_WPROT_EN
      exp_wr++;
`endif
      check("wp_locked_wr_cnt", n_wr, exp_wr);
      frame(16'hC0A5, 16, r);
      frame(16'h4211, 16, r);
      exp_frm += 2;
      exp_wr++;
      check("wp_unlocked_wr_cnt", n_wr, exp_wr);
      frame(16'h0200, 16, r);
      exp_frm++;
      check("wp_rd02", bus.rd_data, 8'h11);
      frame(16'h4233, 16, r);
      frame(16'h0200, 16, r);
      exp_frm += 2;
`ifdef CAL_WPROT_EN
      check("wp_consumed_rd02", bus.rd_data, 8'h11);
`else
      exp_wr++;
      check("wp_consumed_rd02", bus.rd_data, 8'h33);
`endif
      check("wp_consumed_wr_cnt", n_wr, exp_wr);
      check("frm_cnt3", n_frm, exp_frm);

      bus.SS_n = 1'b0;
      repeat (8) @(negedge clk);
      bus.SCLK = 1'b0;
      bus.MOSI = 1'b1;
      repeat (8) @(negedge clk);
      bus.SCLK = 1'b1;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_rd_data", bus.rd_data, 8'h00);
      check("midrst_miso_z", miso, 1'b1);
      bus.SS_n = 1'b1;
      bus.SCLK = 1'b1;
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      frame(16'h0A00, 16, r);
      exp_frm++;
      check("midrst_store_init", bus.rd_data, 8'h00);
      check("frm_cnt4", n_frm, exp_frm);
      check("miso_stable", unstable, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_eep_slave.md
Name: spi_eep_slave

Overview:
Synthesizable SPI responder modelling the calibration EEPROM on the DSO SPI bus. It is the other end of the SPI master: it accepts the master's 16-bit frames on MOSI, decodes read and write commands against a 64x8 calibration store, and returns read data on MISO in the following frame. All SPI inputs are oversampled in the clk domain; SCLK is clk/16.

Parameters:
ADDR_W, 6, address width; store depth = 2**ADDR_W bytes
INIT_VAL, 8'h00, value loaded into every store location at reset

Ports:
clk  input  1  system clock (40MHz)
rst_n  input  1  reset, asynchronous, active-low
SS_n  input  1  slave select from SPI master, active low
SCLK  input  1  SPI clock from master, idles high
MOSI  input  1  serial data from master, MSB first
MISO  output  1  serial data to master; high-Z while synchronized SS_n is high
frm_done  output  1  one-clk pulse when a full 16-bit frame has been received
wr_done  output  1  one-clk pulse when a write has been committed to the store
rd_data  output  8  response byte staged for the next frame (debug/visibility)

Behaviour:
- Reset: all store bytes = INIT_VAL; rd_data=0; frm_done=0; wr_done=0; bit counter=0; shift registers=0; synchronizer flops for SS_n/SCLK = 1, MOSI = 0; MISO=Z.
- Synchronization: SS_n, SCLK and MOSI each pass through two flops; one extra flop on SCLK for edge detection. Rise = prev 0, cur 1; fall = prev 1, cur 0. Edge-to-action latency is 3 clk.
- States: IDLE, SHIFT, DONE.
- IDLE: wait for synchronized SS_n = 0. On entry to SHIFT: bit_cnt=0; tx_shift={8'h00, rd_data}; MISO drives tx_shift[15].
- SHIFT:
  - On SCLK rise: rx_shift={rx_shift[14:0], MOSI_sync}; bit_cnt++.
  - On SCLK fall, if bit_cnt != 0: tx_shift shifts left 1, and MISO = new tx_shift[15].
  - When bit_cnt reaches 16: go to DONE.
  - SS_n rising before 16 bits: abort to IDLE; no decode, no pulses, store and rd_data unchanged.
- DONE (1 clk): frm_done=1. Decode rx_shift: [15:14]=op, [13:8]=addr (ADDR_W bits, upper bits ignored), [7:0]=data.
  - op 2'b01 write: store[addr]=data; wr_done=1 same clk.
  - op 2'b00 read: rd_data=store[addr]; returned as MISO bits [7:0] of the next frame.
  - op 2'b1x: no effect on store or rd_data.
- Leaving DONE: wait for SS_n high, then go to IDLE. SCLK edges while SS_n stays low after 16 bits are ignored; no further bits are captured.
- Same-frame read-after-write is impossible by construction: one op per frame.
- Back-to-back frames need SS_n high for at least 3 clk; the master's inter-frame gap satisfies this.
- Reset asserted mid-frame: immediate return to reset state. The store is reinitialized to INIT_VAL.

Optional Feature:
CAL_WPROT_EN:
- When defined: addresses 0x00-0x0F are write-protected.
  - A write there commits only if the immediately preceding complete frame was op 2'b11 with data 8'hA5 (unlock).
  - The unlock is consumed by the next complete frame, whatever its op.
  - A blocked write still pulses frm_done but not wr_done.
- When undefined: all addresses are writable and op 2'b11 is a no-op.

Test Plan:
- Reset, then frame 16'h0000 (read addr 0), then frame 16'h0000 -> second frame MISO returns 16'h0000; rd_data=8'h00; frm_done pulses twice.
- Write 16'h4A3C (addr 0x0A, data 8'h3C), then read 16'h0A00, then read 16'h0000 -> wr_done pulses once; third frame MISO low byte = 8'h3C, high byte = 8'h00.
- Abort: SS_n deasserted after 9 SCLKs of 16'h4555 -> no frm_done, no wr_done; a later read of addr 0x05 returns 8'h00.
- Extra clocks: 20 SCLKs with SS_n low carrying 16'h7F81 -> exactly one write (addr 0x3F = 8'h81); the extra 4 edges are ignored.
- MISO high-Z whenever SS_n is high; MISO is driven and stable from each SCLK fall to the next SCLK rise during a frame.
- With CAL_WPROT_EN: write 16'h4211 is blocked (no wr_done); frame 16'hC0A5, then 16'h4211 -> wr_done pulses; a read of addr 0x02 returns 8'h11.
